top_r2b_converter: RTL

TOP_R2B_CONVERTER -- requirements
Module: top_r2b_converter

---
 rtl/top_r2b_converter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/top_r2b_converter.sv
// rtl/top_r2b_converter.sv - row-major tile stream to BLOCK_SIZE x BLOCK_SIZE block stream converter
//
// Accepts a matrix as row-major tiles of TILE_SIZE elements and emits it as
// square blocks, one row-group (BLOCK_SIZE rows) at a time, using two
// ping-pong banks so one row-group can fill while the other drains.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input tile present
//   in_ready   converter accepts a tile this cycle
//   in_data    one tile, element i at [i*WIDTH +: WIDTH]
//   out_valid  output block present
//   out_ready  consumer accepts the block
//   out_data   one block, element (r,c) at [(r*BLOCK_SIZE+c)*WIDTH +: WIDTH]
//   done       one-cycle pulse after the last block of a matrix is transferred
module top_r2b_converter #(
    parameter int WIDTH      = 16,
    parameter int ROW        = 256,
    parameter int COL        = 64,
    parameter int BLOCK_SIZE = 2,
    parameter int TILE_SIZE  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [TILE_SIZE*WIDTH-1:0]           in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH-1:0] out_data,
    output logic                                 done
);

    localparam int TILES = COL / TILE_SIZE;
    localparam int NBLK  = COL / BLOCK_SIZE;
    localparam int NGRP  = ROW / BLOCK_SIZE;
    localparam int TW    = (TILES > 1)      ? $clog2(TILES)      : 1;
    localparam int RW    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int BW    = (NBLK > 1)       ? $clog2(NBLK)       : 1;
    localparam int GW    = (NGRP > 1)       ? $clog2(NGRP)       : 1;
    localparam int BLKW  = BLOCK_SIZE * BLOCK_SIZE * WIDTH;

    localparam logic [TW-1:0] TILE_LAST = TW'(TILES - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(BLOCK_SIZE - 1);
    localparam logic [BW-1:0] BLK_LAST  = BW'(NBLK - 1);
    localparam logic [GW-1:0] GRP_LAST  = GW'(NGRP - 1);

    if (COL % TILE_SIZE != 0) begin : g_chk_tile
        $error("COL must be a multiple of TILE_SIZE");
    end
    if (COL % BLOCK_SIZE != 0) begin : g_chk_col
        $error("COL must be a multiple of BLOCK_SIZE");
    end
    if (ROW % BLOCK_SIZE != 0) begin : g_chk_row
        $error("ROW must be a multiple of BLOCK_SIZE");
    end

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    bank_state_e     bank_q [2];
    bank_state_e     bank_d [2];
    logic            wr_sel_q, wr_sel_d;
    logic            rd_sel_q, rd_sel_d;
    logic [TW-1:0]   tile_idx_q, tile_idx_d;
    logic [RW-1:0]   row_in_grp_q, row_in_grp_d;
    logic [BW-1:0]   blk_idx_q, blk_idx_d;
    logic [GW-1:0]   grp_out_q, grp_out_d;
    logic            done_q, done_d;
    // Holds in_ready low through reset and releases it on the first edge after.
    logic            ready_en_q;

    logic            wr_fire, rd_fire, fill_last, drain_last;
    logic [BLKW-1:0] blk_data [2][NBLK];

    assign in_ready   = ready_en_q && (bank_q[wr_sel_q] != BANK_FULL);
    assign out_valid  = (bank_q[rd_sel_q] == BANK_FULL);
    assign wr_fire    = in_valid && in_ready;
    assign rd_fire    = out_valid && out_ready;
    assign fill_last  = wr_fire && (tile_idx_q == TILE_LAST) && (row_in_grp_q == ROW_LAST);
    assign drain_last = rd_fire && (blk_idx_q == BLK_LAST);
    assign done       = done_q;

    // Gating by out_valid keeps out_data at zero whenever no block is offered,
    // including during reset, without clearing the bank storage.
    assign out_data   = out_valid ? blk_data[rd_sel_q][blk_idx_q] : '0;

    always_comb begin
        bank_d       = bank_q;
        wr_sel_d     = wr_sel_q;
        rd_sel_d     = rd_sel_q;
        tile_idx_d   = tile_idx_q;
        row_in_grp_d = row_in_grp_q;
        blk_idx_d    = blk_idx_q;
        grp_out_d    = grp_out_q;
        done_d       = 1'b0;

        if (wr_fire) begin
            if (tile_idx_q == TILE_LAST) begin
                tile_idx_d   = '0;
                row_in_grp_d = (row_in_grp_q == ROW_LAST) ? '0 : row_in_grp_q + RW'(1);
            end else begin
                tile_idx_d = tile_idx_q + TW'(1);
            end
            bank_d[wr_sel_q] = fill_last ? BANK_FULL : BANK_FILLING;
            if (fill_last) begin
                wr_sel_d = ~wr_sel_q;
            end
        end

        // The fill bank is never FULL and the drain bank always is, so the two
        // updates above and below can never target the same bank.
        if (rd_fire) begin
            blk_idx_d = drain_last ? '0 : blk_idx_q + BW'(1);
        end
        if (drain_last) begin
            bank_d[rd_sel_q] = BANK_EMPTY;
            rd_sel_d         = ~rd_sel_q;
            grp_out_d        = (grp_out_q == GRP_LAST) ? '0 : grp_out_q + GW'(1);
            done_d           = (grp_out_q == GRP_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]    <= BANK_EMPTY;
            bank_q[1]    <= BANK_EMPTY;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            tile_idx_q   <= '0;
            row_in_grp_q <= '0;
            blk_idx_q    <= '0;
            grp_out_q    <= '0;
            done_q       <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            tile_idx_q   <= tile_idx_d;
            row_in_grp_q <= row_in_grp_d;
            blk_idx_q    <= blk_idx_d;
            grp_out_q    <= grp_out_d;
            done_q       <= done_d;
            ready_en_q   <= 1'b1;
        end
    end

    // One register per bank element; each is written from its fixed tile lane
    // and wired straight into its slot of the block it belongs to.
    for (genvar k = 0; k < 2; k++) begin : g_bank
        for (genvar r = 0; r < BLOCK_SIZE; r++) begin : g_row
            for (genvar c = 0; c < COL; c++) begin : g_col
                logic [WIDTH-1:0] cell_q;

                always_ff @(posedge clk) begin
                    if (wr_fire && (wr_sel_q == 1'(k)) && (row_in_grp_q == RW'(r)) &&
                        (tile_idx_q == TW'(c / TILE_SIZE))) begin
                        cell_q <= in_data[(c % TILE_SIZE)*WIDTH +: WIDTH];
                    end
                end

                assign blk_data[k][c / BLOCK_SIZE][(r*BLOCK_SIZE + c % BLOCK_SIZE)*WIDTH +: WIDTH] = cell_q;
            end
        end
    end

endmodule
